// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A master keeps the bus for as long as it holds cyc; a watchdog aborts any
// strobed transfer that the slave leaves unanswered for TIMEOUT_CYCLES cycles.
//
// Handshake: a transfer is offered while the owner's cyc and stb are high. It
// completes in the cycle s_ack_i or s_err_i is high, or when the watchdog
// fires, which returns an error to the owner and drops s_cyc_o/s_stb_o for
// that cycle.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      dbg_state_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [PW-1:0]            owner_q, owner_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [7:0]               wdog_q, wdog_d;
  logic [7:0]               wdog_inc;
  logic                     own_cyc, own_stb, waiting, timeout;
  logic                     pick_found;
  logic [PW-1:0]            pick_idx, cand_idx;

  // Owner's request lines; stb only counts while cyc is also high
  assign own_cyc = m_cyc_i[owner_q];
  assign own_stb = m_cyc_i[owner_q] & m_stb_i[owner_q];

  // The watchdog register holds the number of unanswered cycles already
  // seen, so the current cycle is wait number wdog_q+1; the abort fires on
  // the cycle that would make the count reach TIMEOUT_CYCLES.
  assign waiting  = (state_q == OWNED) & own_stb & ~s_ack_i & ~s_err_i;
  assign wdog_inc = wdog_q + 8'd1;
  assign timeout  = waiting && (wdog_inc == 8'(TIMEOUT_CYCLES));

  assign m_dat_o     = s_dat_i;
  assign grant_o     = grant_q;
  assign dbg_state_o = (state_q == OWNED);

  // Round-robin pick: first requester scanning upward from ptr+1 with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_idx = PW'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!pick_found && m_cyc_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic for ownership, pointer and watchdog
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wdog_d  = (waiting && !timeout) ? wdog_inc : 8'd0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = OWNED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          ptr_d             = pick_idx;
        end
      end
      OWNED: begin
        // Releasing cyc always passes through IDLE, even with others waiting
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= PW'(NUM_MASTERS - 1);
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Slave-side mux from the owner and response routing back to it
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == OWNED) begin
      s_cyc_o          = own_cyc & ~timeout;
      s_stb_o          = own_stb & ~timeout;
      s_we_o           = m_we_i[owner_q];
      s_sel_o          = m_sel_i[int'(owner_q)*4 +: 4];
      s_adr_o          = m_adr_i[int'(owner_q)*32 +: 32];
      s_dat_o          = m_dat_i[int'(owner_q)*32 +: 32];
      m_ack_o[owner_q] = s_ack_i;
      m_err_o[owner_q] = s_err_i | timeout;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (4 masters, 16-cycle watchdog).
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [4*N-1:0]  m_sel = '0;
  logic [32*N-1:0] m_adr = '0, m_dat = '0;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o, dbg_state_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [31:0]     s_dat = '0;
  logic            s_ack = 1'b0, s_err = 1'b0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; checks then see settled state.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int idx, input logic cyc, input logic stb,
                            input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[idx]         = cyc;
    m_stb[idx]         = stb;
    m_we[idx]          = we;
    m_sel[idx*4 +: 4]  = sel;
    m_adr[idx*32 +: 32] = adr;
    m_dat[idx*32 +: 32] = dat;
  endtask

  task automatic release_all();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    step();
    step();
  endtask

  logic [N-1:0] exp_g;

  initial begin
    // ---- reset held 3 cycles with every master requesting ----
    rst_n = 1'b0;
    m_cyc = '1;
    m_stb = '1;
    s_ack = 1'b1;
    s_err = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_grant", 32'(grant_o), 32'h0);
      check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
      check("rst_ack",   32'(m_ack_o), 32'h0);
      check("rst_err",   32'(m_err_o), 32'h0);
    end
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    rst_n = 1'b1;
    step();

    // ---- single master 1 write ----
    set_master(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'hEEEEEEEE);
    #1;
    check("single_latency", 32'(grant_o), 32'h0);
    step();
    check("single_grant", 32'(grant_o), 32'h2);
    check("single_s_dat", s_dat_o, 32'hEEEEEEEE);
    check("single_s_we",  32'(s_we_o), 32'h1);
    check("single_s_sel", 32'(s_sel_o), 32'hF);
    check("single_s_adr", s_adr_o, 32'h0);
    s_ack = 1'b1;
    #1;
    check("single_ack", 32'(m_ack_o), 32'h2);
    check("single_err", 32'(m_err_o), 32'h0);
    step();
    s_ack = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("single_s_cyc_drop", 32'(s_cyc_o), 32'h0);
    step();
    check("single_release", 32'(grant_o), 32'h0);

    // ---- round robin between masters 0 and 2 after a fresh reset ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    set_master(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    step();
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      check("rr_grant", 32'(grant_o), 32'(exp_g));
      s_ack = 1'b1;
      #1;
      check("rr_ack", 32'(m_ack_o), 32'(exp_g));
      step();
      s_ack = 1'b0;
      m_cyc = m_cyc & ~exp_g;
      m_stb = m_stb & ~exp_g;
      step();
      check("rr_idle_gap", 32'(grant_o), 32'h0);
      m_cyc = m_cyc | exp_g;
      m_stb = m_stb | exp_g;
      step();
    end
    release_all();

    // ---- watchdog timeout on master 3 ----
    set_master(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    step();
    check("to_grant", 32'(grant_o), 32'h8);
    for (int c = 1; c <= TO; c++) begin
      if (c < TO) begin
        check("to_wait_err", 32'(m_err_o), 32'h0);
        check("to_wait_stb", 32'(s_stb_o), 32'h1);
      end else begin
        check("to_err",   32'(m_err_o), 32'h8);
        check("to_s_stb", 32'(s_stb_o), 32'h0);
        check("to_s_cyc", 32'(s_cyc_o), 32'h0);
      end
      step();
    end
    check("to_after_err",  32'(m_err_o), 32'h0);
    check("to_after_stb",  32'(s_stb_o), 32'h1);
    check("to_grant_kept", 32'(grant_o), 32'h8);
    release_all();

    // ---- slave error on master 0 read ----
    set_master(0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 32'h0);
    step();
    check("serr_grant", 32'(grant_o), 32'h1);
    s_dat = 32'h12345678;
    s_err = 1'b1;
    #1;
    check("serr_err", 32'(m_err_o), 32'h1);
    check("serr_ack", 32'(m_ack_o), 32'h0);
    check("serr_dat", m_dat_o, 32'h12345678);
    step();
    s_err = 1'b0;
    release_all();

    // ---- ack arriving on the would-be timeout cycle ----
    set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h44, 32'h0);
    step();
    for (int c = 1; c < TO; c++) step();
    s_ack = 1'b1;
    #1;
    check("late_ack_err", 32'(m_err_o), 32'h0);
    check("late_ack_ack", 32'(m_ack_o), 32'h1);
    check("late_ack_stb", 32'(s_stb_o), 32'h1);
    step();
    s_ack = 1'b0;
    #1;
    check("late_ack_next_err", 32'(m_err_o), 32'h0);
    release_all();

    // ---- reset while master 2 owns, then 0/2 contention ----
    set_master(2, 1'b1, 1'b1, 1'b1, 4'hF, 32'h500, 32'hA5A5A5A5);
    step();
    check("mid_grant", 32'(grant_o), 32'h4);
    set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    rst_n = 1'b0;
    s_ack = 1'b1;
    step();
    check("mid_rst_grant", 32'(grant_o), 32'h0);
    check("mid_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("mid_rst_s_stb", 32'(s_stb_o), 32'h0);
    check("mid_rst_ack",   32'(m_ack_o), 32'h0);
    check("mid_rst_err",   32'(m_err_o), 32'h0);
    rst_n = 1'b1;
    s_ack = 1'b0;
    step();
    check("mid_rst_winner", 32'(grant_o), 32'h1);
    check("mid_rst_adr",    s_adr_o, 32'h600);
    release_all();

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of Wishbone masters sharing one slave port.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, cycles a strobed transfer may wait for ack/err before the arbiter aborts it; legal range 1..255.
REQ-003 wb_clk_i  input  1  single clock for all logic.
REQ-004 wb_rst_i  input  1  reset, synchronous and active-low.
REQ-005 m_cyc_i, m_stb_i, m_we_i  input  NUM_MASTERS each  per-master cycle, strobe and write-enable; bit i belongs to master i.
REQ-006 m_sel_i  input  4*NUM_MASTERS  byte selects; master i at [4i+3:4i].
REQ-007 m_adr_i, m_dat_i  input  32*NUM_MASTERS each  address and write data; master i at [32i+31:32i].
REQ-008 m_dat_o  output  32  read data, common to all masters.
REQ-009 m_ack_o, m_err_o  output  NUM_MASTERS each  per-master acknowledge and error.
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave-side cycle, strobe, write-enable.
REQ-011 s_sel_o  output  4; s_adr_o, s_dat_o  output  32 each  slave-side selects, address, write data.
REQ-012 s_dat_i  input  32; s_ack_i, s_err_i  input  1 each  slave read data, acknowledge, error.
REQ-013 grant_o  output  NUM_MASTERS  one-hot current owner, all-zero when no owner.

Function
REQ-014 The block SHALL implement FSM states IDLE and OWNED; grant_o, the owner index and the round-robin pointer SHALL be registered.
REQ-015 In IDLE with any m_cyc_i bit high, the arbiter SHALL select the first requesting master scanning from pointer+1 upward with wrap-around, and enter OWNED with grant_o set on the next clock edge (one-cycle arbitration latency).
REQ-016 On each grant the pointer SHALL be loaded with the granted index, so the granted master has lowest priority at the next arbitration.
REQ-017 In OWNED, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow the owner's inputs; all slave outputs SHALL be zero when no owner.
REQ-018 m_dat_o SHALL equal s_dat_i at all times; s_ack_i and s_err_i SHALL route only to the owner's m_ack_o/m_err_o bit, all other bits zero.
REQ-019 Ownership SHALL persist while the owner holds m_cyc_i, across any number of transfers; requests from other masters SHALL NOT preempt.
REQ-020 When the owner drops m_cyc_i, the arbiter SHALL return to IDLE on the next edge with grant_o cleared, giving at least one idle cycle between owners even if other requests are pending.
REQ-021 An 8-bit watchdog SHALL count cycles in OWNED with owner strobe high and neither s_ack_i nor s_err_i high; it SHALL clear on ack, err, strobe low or leaving OWNED.
REQ-022 When the watchdog equals TIMEOUT_CYCLES, the arbiter SHALL assert the owner's m_err_o for exactly that one cycle, force s_cyc_o and s_stb_o low that cycle, and clear the watchdog; ownership SHALL be retained.
REQ-023 If s_ack_i or s_err_i arrives in the same cycle the watchdog reaches TIMEOUT_CYCLES, the slave response SHALL win and no timeout error SHALL be generated.
REQ-024 Masters whose m_cyc_i is low SHALL never be granted; m_stb_i without m_cyc_i SHALL be ignored.

Reset
REQ-025 While wb_rst_i is low at a clock edge the FSM SHALL enter IDLE, grant_o and watchdog SHALL clear, and the pointer SHALL load NUM_MASTERS-1 so master 0 has top priority after reset.
REQ-026 Reset mid-transaction SHALL drop ownership immediately; all slave outputs, m_ack_o and m_err_o SHALL be zero in the cycle following the reset edge.

Verification
REQ-027 Reset: hold wb_rst_i low 3 cycles with all m_cyc_i high -> grant_o=0, s_cyc_o=0, m_ack_o=0, m_err_o=0.
REQ-028 Single master: master 1 writes 32'hEEEEEEEE to address 0, sel 4'hF; slave acks next cycle -> grant_o=4'b0010 one cycle after m_cyc_i[1], s_dat_o=32'hEEEEEEEE, m_ack_o=4'b0010 only.
REQ-029 Round robin: masters 0 and 2 request continuously after reset, each releasing after one acked transfer -> grant order 0,2,0,2 with one idle cycle between owners.
REQ-030 Timeout: TIMEOUT_CYCLES=16, master 3 strobes, slave never responds -> m_err_o=4'b1000 for one cycle at the 16th wait cycle, s_stb_o low that cycle, grant retained.
REQ-031 Slave error and late ack: slave asserts s_err_i on master 0's read; separately ack arrives on the timeout cycle -> m_err_o[0] from slave error only, no timeout error in the second case.
REQ-032 Reset mid-transfer: assert reset while master 2 owns with strobe high -> next cycle grant_o=0, s_cyc_o=0; after release master 0 wins a 0/2 contention.
